// File: rtl/pmod_ad1_capture.sv
// PMOD AD1 capture: drives both AD7476A converters and deserialises
// their samples into a 32-bit word with a valid/ready handshake.
module pmod_ad1_capture #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int QUIET_CYCLES  = 4,
    parameter int C_DATA_WIDTH  = 32
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETN,
    input  logic                    enable,
    output logic                    ad_cs_n,
    output logic                    ad_sclk,
    input  logic                    ad_sdata0,
    input  logic                    ad_sdata1,
    output logic [C_DATA_WIDTH-1:0] sample_data,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy,
    output logic [15:0]             sample_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TAIL,
        QUIET
    } state_t;

    localparam int DMAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CW   = $clog2(DMAX + 1);
    localparam int PW   = $clog2(SAMPLE_PERIOD + 1);

    localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST  = CW'(QUIET_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   div_q, div_d;
    logic [3:0]      bit_q, bit_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            shift_en;
    logic            load;
    logic            sd0_q, sd1_q;
    logic [11:0]     sh0_q, sh1_q;
    logic [PW-1:0]   per_q;
    logic            tick;
    logic [31:0]     data_q;
    logic            valid_q;
    logic            ovr_q;
    logic            ovr_set;
    logic [15:0]     count_q;

    assign tick = enable && (per_q == '0);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            per_q <= '0;
        end else if (!enable) begin
            per_q <= '0;
        end else if (per_q == '0) begin
            per_q <= PERIOD_LAST;
        end else begin
            per_q <= per_q - PW'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sd0_q <= 1'b0;
            sd1_q <= 1'b0;
        end else begin
            sd0_q <= ad_sdata0;
            sd1_q <= ad_sdata1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        shift_en = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (tick) begin
                    state_d = LEAD;
                    div_d   = '0;
                    cs_n_d  = 1'b0;
                end
            end
            LEAD: begin
                if (div_q == DIV_LAST) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CW'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d   = 1'b1;
                        shift_en = 1'b1;
                    end else if (bit_q == 4'd15) begin
                        state_d = TAIL;
                    end else begin
                        bit_d  = bit_q + 4'd1;
                        sclk_d = 1'b0;
                    end
                end
            end
            // cs_n held low one extra half-period after the last SCLK high
            TAIL: begin
                if (div_q == DIV_LAST) begin
                    state_d = QUIET;
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    load    = 1'b1;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            QUIET: begin
                if (div_q == QUIET_LAST) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // 12-bit shifters: the four leading bits fall off the top
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sh0_q <= '0;
            sh1_q <= '0;
        end else if (shift_en) begin
            sh0_q <= {sh0_q[10:0], sd0_q};
            sh1_q <= {sh1_q[10:0], sd1_q};
        end
    end

    assign ovr_set = load && valid_q && !sample_ready;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else if (load) begin
            count_q <= count_q + 16'd1;
            if (!valid_q || sample_ready) begin
                data_q  <= {4'h0, sh1_q, 4'h0, sh0_q};
                valid_q <= 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (overrun_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign ad_cs_n      = cs_n_q;
    assign ad_sclk      = sclk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != IDLE);
    assign sample_count = count_q;

endmodule

// File: tb/tb_pmod_ad1_capture.sv
// Bench for pmod_ad1_capture: converter model, frame monitor and
// an arithmetic reference for packing, timing and counters.
module tb_pmod_ad1_capture;

    localparam int D = 2;
    localparam int P = 100;
    localparam int Q = 4;
    localparam int LAT = 34 * D + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        ad_sdata0 = 1'b0;
    logic        ad_sdata1 = 1'b0;
    logic        ready = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        ad_cs_n;
    logic        ad_sclk;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        overrun;
    logic        busy;
    logic [15:0] sample_count;

    pmod_ad1_capture #(
        .CLK_DIV      (D),
        .SAMPLE_PERIOD(P),
        .QUIET_CYCLES (Q),
        .C_DATA_WIDTH (32)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .enable       (enable),
        .ad_cs_n      (ad_cs_n),
        .ad_sclk      (ad_sclk),
        .ad_sdata0    (ad_sdata0),
        .ad_sdata1    (ad_sdata1),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (ready),
        .overrun      (overrun),
        .overrun_clr  (ovr_clr),
        .busy         (busy),
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // packing rule in plain arithmetic
    function automatic logic [31:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        return ((32'(b) % 32'd4096) * 32'd65536) + (32'(a) % 32'd4096);
    endfunction

    function automatic int q0(input int q[$]);
        return (q.size() > 0) ? q[0] : -1;
    endfunction

    // converter: new bit on every SCLK falling edge, MSB first
    logic [15:0] conv0_q[$];
    logic [15:0] conv1_q[$];
    logic [15:0] w0 = '0;
    logic [15:0] w1 = '0;
    int idx = 0;

    always @(negedge ad_cs_n) begin
        idx = 16;
        w0 = (conv0_q.size() > 0) ? conv0_q.pop_front() : 16'h0;
        w1 = (conv1_q.size() > 0) ? conv1_q.pop_front() : 16'h0;
    end

    always @(negedge ad_sclk) begin
        if (!ad_cs_n && idx > 0) begin
            idx--;
            ad_sdata0 = w0[idx];
            ad_sdata1 = w1[idx];
        end
    end

    int fall_q[$];
    int len_q[$];
    int rise_q[$];
    int vrise_q[$];
    int acc_t_q[$];
    logic [31:0] acc_q[$];
    logic p_cs = 1'b1;
    logic p_sclk = 1'b1;
    logic p_valid = 1'b0;
    int cs_len = 0;
    int rises = 0;

    always @(negedge clk) begin
        #1;
        if (!ad_cs_n) begin
            if (p_cs) begin
                fall_q.push_back(cyc);
                cs_len = 0;
                rises = 0;
            end
            cs_len++;
            if (!p_sclk && ad_sclk) rises++;
        end else if (!p_cs) begin
            len_q.push_back(cs_len);
            rise_q.push_back(rises);
        end
        if (sample_valid && !p_valid) vrise_q.push_back(cyc);
        if (sample_valid && ready) begin
            acc_q.push_back(sample_data);
            acc_t_q.push_back(cyc);
        end
        p_cs = ad_cs_n;
        p_sclk = ad_sclk;
        p_valid = sample_valid;
    end

    task automatic clear_mon();
        fall_q.delete();
        len_q.delete();
        rise_q.delete();
        vrise_q.delete();
        acc_q.delete();
        acc_t_q.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run(input int n, output int c);
        @(negedge clk);
        enable = 1'b1;
        c = cyc;
        repeat ((n - 1) * P + 1) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    logic [15:0] a, b;
    logic [31:0] exp_q[$];
    logic [31:0] first_w;
    int exp_count = 0;
    int c;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(ad_cs_n), 32'd1);
        chk("rst_sclk", 32'(ad_sclk), 32'd1);
        chk("rst_data", sample_data, 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clear_mon();
        conv0_q.push_back(16'h0A5C);
        conv1_q.push_back(16'h03F1);
        run(1, c);
        exp_count++;
        chk("t1_frames", 32'(fall_q.size()), 32'd1);
        chk("t1_cs_fall", 32'(q0(fall_q) - c), 32'd1);
        chk("t1_cs_len", 32'(q0(len_q)), 32'(34 * D));
        chk("t1_rises", 32'(q0(rise_q)), 32'd16);
        chk("t1_lat", 32'(q0(vrise_q) - c), 32'(LAT));
        chk("t1_data", sample_data, 32'h03F10A5C);
        chk("t1_valid", 32'(sample_valid), 32'd1);
        chk("t1_count", 32'(sample_count), 32'(exp_count));
        consume();
        chk("t1_valid_clr", 32'(sample_valid), 32'd0);

        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            conv0_q.push_back(a);
            conv1_q.push_back(b);
            exp_q.push_back(model(a, b));
        end
        ready = 1'b1;
        run(5, c);
        ready = 1'b0;
        exp_count += 5;
        chk("t2_n", 32'(acc_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_data", acc_q[i], exp_q[i]);
            chk("t2_time", 32'(acc_t_q[i] - c), 32'(LAT + P * i));
        end
        chk("t2_ovr", 32'(overrun), 32'd0);
        chk("t2_count", 32'(sample_count), 32'(exp_count));
        chk("t2_valid", 32'(sample_valid), 32'd0);

        a = 16'($urandom);
        b = 16'($urandom);
        conv0_q.push_back(16'h0111);
        conv1_q.push_back(a);
        conv0_q.push_back(16'h0222);
        conv1_q.push_back(b);
        first_w = model(16'h0111, a);
        run(2, c);
        exp_count += 2;
        chk("t3_data", sample_data, first_w);
        chk("t3_valid", 32'(sample_valid), 32'd1);
        chk("t3_ovr", 32'(overrun), 32'd1);
        chk("t3_count", 32'(sample_count), 32'(exp_count));
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'd0);
        conv0_q.push_back(16'($urandom));
        conv1_q.push_back(16'($urandom));
        @(negedge clk);
        enable = 1'b1;
        c = cyc;
        @(negedge clk);
        enable = 1'b0;
        while (cyc < c + 34 * D) @(negedge clk);
        chk("t3_ovr_pre", 32'(overrun), 32'd0);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("t3_set_wins", 32'(overrun), 32'd1);
        chk("t3_data_hold", sample_data, first_w);
        exp_count++;
        wait_idle();
        chk("t3_count2", 32'(sample_count), 32'(exp_count));

        consume();
        clear_mon();
        a = 16'($urandom);
        b = 16'($urandom);
        conv0_q.push_back(a);
        conv1_q.push_back(b);
        @(negedge clk);
        enable = 1'b1;
        c = cyc;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        exp_count++;
        chk("t4_lat", 32'(q0(vrise_q) - c), 32'(LAT));
        chk("t4_data", sample_data, model(a, b));
        chk("t4_count", 32'(sample_count), 32'(exp_count));
        repeat (500) @(negedge clk);
        chk("t4_no_more", 32'(fall_q.size()), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        conv0_q.push_back(16'($urandom));
        conv1_q.push_back(16'($urandom));
        a = 16'($urandom);
        b = 16'($urandom);
        conv0_q.push_back(a);
        conv1_q.push_back(b);
        @(negedge clk);
        enable = 1'b1;
        c = cyc;
        while (cyc < c + 20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_cs_n", 32'(ad_cs_n), 32'd1);
        chk("t5_sclk", 32'(ad_sclk), 32'd1);
        chk("t5_valid", 32'(sample_valid), 32'd0);
        chk("t5_count", 32'(sample_count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        clear_mon();
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        @(negedge clk);
        enable = 1'b0;
        wait_idle();
        exp_count = 1;
        chk("t5_fall", 32'(q0(fall_q) - c), 32'd1);
        chk("t5_lat", 32'(q0(vrise_q) - c), 32'(LAT));
        chk("t5_data", sample_data, model(a, b));
        chk("t5_count2", 32'(sample_count), 32'(exp_count));

        consume();
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.count_q;
        chk("t6_preset", 32'(sample_count), 32'h0000FFFF);
        a = 16'hF000 | 16'($urandom_range(0, 4095));
        b = 16'hF000 | 16'($urandom_range(0, 4095));
        conv0_q.push_back(a);
        conv1_q.push_back(b);
        run(1, c);
        chk("t6_wrap", 32'(sample_count), 32'd0);
        chk("t6_data", sample_data, model(a, b));
        chk("t6_nibbles", sample_data & 32'hF000F000, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
